// File: rtl/pkt_buf_wr_if.sv
// ---------------------------------------------------------------------------
// pkt_buf_wr_if
// Bundles the packet word stream feeding the buffer writer and the write
// port it drives into the simple-dual-port packet RAM.
//   in_vld/in_sop/in_eop/in_data : input stream, no backpressure
//   ram_wen/ram_waddr/ram_wdata  : registered RAM write port
// modport master : stream source / RAM side (drives in_*, observes ram_*)
// modport slave  : the buffer writer (consumes in_*, drives ram_*)
// ---------------------------------------------------------------------------
interface pkt_buf_wr_if #(
    parameter int unsigned DWID = 64,
    parameter int unsigned AWID = 10
) ();
    logic            in_vld;
    logic            in_sop;
    logic            in_eop;
    logic [DWID-1:0] in_data;
    logic            ram_wen;
    logic [AWID-1:0] ram_waddr;
    logic [DWID-1:0] ram_wdata;

    modport master (
        output in_vld, in_sop, in_eop, in_data,
        input  ram_wen, ram_waddr, ram_wdata
    );

    modport slave (
        input  in_vld, in_sop, in_eop, in_data,
        output ram_wen, ram_waddr, ram_wdata
    );
endinterface

// File: rtl/pkt_buf_wr.sv
// ---------------------------------------------------------------------------
// pkt_buf_wr
// Write side of a packet buffer. Words are written speculatively; a packet
// becomes visible to the reader (wr_ptr_commit) only once its eop has been
// written. Overflowing or malformed packets are rolled back to their start.
// Ports:
//   clk           : clock, all logic on posedge
//   rst           : synchronous active-low reset
//   bus (slave)   : input stream + registered RAM write port
//   rd_ptr        : reader pointer incl. wrap bit
//   wr_ptr_commit : committed write pointer incl. wrap bit
//   nfull         : speculative occupancy below depth (combinational)
//   pkt_cnt       : committed packets, wraps
//   drop_cnt      : dropped/aborted packets, wraps
//   err           : one-cycle framing error pulse
// ---------------------------------------------------------------------------
module pkt_buf_wr #(
    parameter int unsigned DWID = 64,
    parameter int unsigned AWID = 10
) (
    input  logic            clk,
    input  logic            rst,
    pkt_buf_wr_if.slave     bus,
    input  logic [AWID:0]   rd_ptr,
    output logic [AWID:0]   wr_ptr_commit,
    output logic            nfull,
    output logic [15:0]     pkt_cnt,
    output logic [15:0]     drop_cnt,
    output logic            err
);

    localparam logic [AWID:0] DEPTH = {1'b1, {AWID{1'b0}}};
    localparam logic [AWID:0] ONE   = (AWID+1)'(1);

    typedef enum logic [1:0] {IDLE, WRITE, DROP} state_t;

    state_t          state, state_n;
    logic [AWID:0]   wptr, wptr_n;
    logic [AWID:0]   sptr, sptr_n;
    logic            commit_pend, commit_n;
    logic [AWID:0]   commit_val, commit_val_n;
    logic            wen_n;
    logic [AWID-1:0] waddr_n;
    logic [DWID-1:0] wdata_n;
    logic            err_n;
    logic [1:0]      drop_inc;

    // A sop inside an open packet rolls back to sptr before being handled,
    // so its write position and full check are based on sptr, not wptr.
    logic [AWID:0]   base;
    logic            full_w;
    logic            full_b;

    always_comb begin
        base   = (state == WRITE) ? sptr : wptr;
        full_w = ((wptr - rd_ptr) == DEPTH);
        full_b = ((base - rd_ptr) == DEPTH);
        nfull  = !full_w;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n      = state;
        wptr_n       = wptr;
        sptr_n       = sptr;
        wen_n        = 1'b0;
        waddr_n      = bus.ram_waddr;
        wdata_n      = bus.ram_wdata;
        err_n        = 1'b0;
        drop_inc     = 2'd0;
        commit_n     = 1'b0;
        commit_val_n = commit_val;

        if (bus.in_vld) begin
            if (bus.in_sop) begin
                // Abort of the open packet (missing eop) or sop while
                // discarding: both are framing errors.
                if (state == WRITE) begin
                    drop_inc = drop_inc + 2'd1;
                    err_n    = 1'b1;
                end else if (state == DROP) begin
                    err_n = 1'b1;
                end

                if (!full_b) begin
                    wen_n   = 1'b1;
                    waddr_n = base[AWID-1:0];
                    wdata_n = bus.in_data;
                    sptr_n  = base;
                    wptr_n  = base + ONE;
                    if (bus.in_eop) begin
                        commit_n     = 1'b1;
                        commit_val_n = base + ONE;
                        state_n      = IDLE;
                    end else begin
                        state_n = WRITE;
                    end
                end else begin
                    drop_inc = drop_inc + 2'd1;
                    wptr_n   = base;
                    state_n  = bus.in_eop ? IDLE : DROP;
                end
            end else begin
                unique case (state)
                    IDLE: begin
                        err_n = 1'b1;
                    end
                    WRITE: begin
                        if (!full_w) begin
                            wen_n   = 1'b1;
                            waddr_n = wptr[AWID-1:0];
                            wdata_n = bus.in_data;
                            wptr_n  = wptr + ONE;
                            if (bus.in_eop) begin
                                commit_n     = 1'b1;
                                commit_val_n = wptr + ONE;
                                state_n      = IDLE;
                            end
                        end else begin
                            wptr_n   = sptr;
                            drop_inc = 2'd1;
                            state_n  = bus.in_eop ? IDLE : DROP;
                        end
                    end
                    DROP: begin
                        if (bus.in_eop) begin
                            state_n = IDLE;
                        end
                    end
                    default: begin
                        state_n = IDLE;
                    end
                endcase
            end
        end
    end

    // Commit is delayed one cycle behind the eop's RAM write so the reader
    // never sees a word in the same cycle it is being written.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr          <= '0;
            sptr          <= '0;
            commit_pend   <= 1'b0;
            commit_val    <= '0;
            wr_ptr_commit <= '0;
            pkt_cnt       <= '0;
            drop_cnt      <= '0;
            err           <= 1'b0;
            bus.ram_wen   <= 1'b0;
            bus.ram_waddr <= '0;
            bus.ram_wdata <= '0;
        end else begin
            wptr          <= wptr_n;
            sptr          <= sptr_n;
            commit_pend   <= commit_n;
            commit_val    <= commit_val_n;
            err           <= err_n;
            drop_cnt      <= drop_cnt + 16'(drop_inc);
            bus.ram_wen   <= wen_n;
            bus.ram_waddr <= waddr_n;
            bus.ram_wdata <= wdata_n;
            if (commit_pend) begin
                wr_ptr_commit <= commit_val;
                pkt_cnt       <= pkt_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_pkt_buf_wr.sv
// ---------------------------------------------------------------------------
// tb_pkt_buf_wr
// Directed bench for pkt_buf_wr at AWID=4 (depth 16), DWID=16.
// ---------------------------------------------------------------------------
module tb_pkt_buf_wr;

    localparam int unsigned DWID = 16;
    localparam int unsigned AWID = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [AWID:0]   rd_ptr = '0;
    logic [AWID:0]   wr_ptr_commit;
    logic            nfull;
    logic [15:0]     pkt_cnt;
    logic [15:0]     drop_cnt;
    logic            err;

    int tests = 0;
    int fails = 0;

    pkt_buf_wr_if #(.DWID(DWID), .AWID(AWID)) bus ();

    pkt_buf_wr #(.DWID(DWID), .AWID(AWID)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .rd_ptr        (rd_ptr),
        .wr_ptr_commit (wr_ptr_commit),
        .nfull         (nfull),
        .pkt_cnt       (pkt_cnt),
        .drop_cnt      (drop_cnt),
        .err           (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        vld, sop, eop;
        logic [15:0] data;
        logic        wen;
        logic [3:0]  addr;
        logic [4:0]  commit;
        logic [15:0] pkt, drop;
        logic        err, nfull;
    } vec_t;

    vec_t vecs[17];

    function automatic vec_t mk(logic vld, logic sop, logic eop, logic [15:0] data,
                                logic wen, logic [3:0] addr, logic [4:0] commit,
                                logic [15:0] pkt, logic [15:0] drop, logic e);
        vec_t v;
        v.vld = vld; v.sop = sop; v.eop = eop; v.data = data;
        v.wen = wen; v.addr = addr; v.commit = commit;
        v.pkt = pkt; v.drop = drop; v.err = e; v.nfull = 1'b1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic vld, input logic sop, input logic eop, input logic [15:0] data);
        bus.in_vld  = vld;
        bus.in_sop  = sop;
        bus.in_eop  = eop;
        bus.in_data = data;
    endtask

    // Advance one clock and land 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, '0);
        step();
        rst = 1'b1;
    endtask

    task automatic chk_word(input string tag, input logic [3:0] addr, input logic [15:0] data);
        chk({tag, " wen"},   32'(bus.ram_wen), 32'd1);
        chk({tag, " addr"},  32'(bus.ram_waddr), 32'(addr));
        chk({tag, " wdata"}, 32'(bus.ram_wdata), 32'(data));
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, '0);
        rst = 1'b0;
        step();
        step();

        // Reset state
        chk("rst wen",    32'(bus.ram_wen), 32'd0);
        chk("rst waddr",  32'(bus.ram_waddr), 32'd0);
        chk("rst wdata",  32'(bus.ram_wdata), 32'd0);
        chk("rst commit", 32'(wr_ptr_commit), 32'd0);
        chk("rst pkt",    32'(pkt_cnt), 32'd0);
        chk("rst drop",   32'(drop_cnt), 32'd0);
        chk("rst err",    32'(err), 32'd0);
        chk("rst nfull",  32'(nfull), 32'd1);
        rst = 1'b1;

        // 4-word packet, stray words in IDLE, sop-abort, single-word packet
        vecs[0]  = mk(1, 1, 0, 16'hA000, 1, 4'd0, 5'd0, 16'd0, 16'd0, 0);
        vecs[1]  = mk(1, 0, 0, 16'hA001, 1, 4'd1, 5'd0, 16'd0, 16'd0, 0);
        vecs[2]  = mk(1, 0, 0, 16'hA002, 1, 4'd2, 5'd0, 16'd0, 16'd0, 0);
        vecs[3]  = mk(1, 0, 1, 16'hA003, 1, 4'd3, 5'd0, 16'd0, 16'd0, 0);
        vecs[4]  = mk(0, 0, 0, 16'h0000, 0, 4'd0, 5'd4, 16'd1, 16'd0, 0);
        vecs[5]  = mk(1, 0, 0, 16'hB000, 0, 4'd0, 5'd4, 16'd1, 16'd0, 1);
        vecs[6]  = mk(1, 0, 1, 16'hB001, 0, 4'd0, 5'd4, 16'd1, 16'd0, 1);
        vecs[7]  = mk(0, 0, 0, 16'h0000, 0, 4'd0, 5'd4, 16'd1, 16'd0, 0);
        vecs[8]  = mk(1, 1, 0, 16'hC000, 1, 4'd4, 5'd4, 16'd1, 16'd0, 0);
        vecs[9]  = mk(1, 0, 0, 16'hC001, 1, 4'd5, 5'd4, 16'd1, 16'd0, 0);
        vecs[10] = mk(1, 0, 0, 16'hC002, 1, 4'd6, 5'd4, 16'd1, 16'd0, 0);
        vecs[11] = mk(1, 1, 0, 16'hC003, 1, 4'd4, 5'd4, 16'd1, 16'd1, 1);
        vecs[12] = mk(1, 0, 0, 16'hC004, 1, 4'd5, 5'd4, 16'd1, 16'd1, 0);
        vecs[13] = mk(1, 0, 1, 16'hC005, 1, 4'd6, 5'd4, 16'd1, 16'd1, 0);
        vecs[14] = mk(0, 0, 0, 16'h0000, 0, 4'd0, 5'd7, 16'd2, 16'd1, 0);
        vecs[15] = mk(1, 1, 1, 16'hD000, 1, 4'd7, 5'd7, 16'd2, 16'd1, 0);
        vecs[16] = mk(0, 0, 0, 16'h0000, 0, 4'd0, 5'd8, 16'd3, 16'd1, 0);

        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].vld, vecs[i].sop, vecs[i].eop, vecs[i].data);
            step();
            chk($sformatf("vec%0d wen", i),    32'(bus.ram_wen), 32'(vecs[i].wen));
            if (vecs[i].wen) begin
                chk($sformatf("vec%0d addr", i),  32'(bus.ram_waddr), 32'(vecs[i].addr));
                chk($sformatf("vec%0d wdata", i), 32'(bus.ram_wdata), 32'(vecs[i].data));
            end
            chk($sformatf("vec%0d commit", i), 32'(wr_ptr_commit), 32'(vecs[i].commit));
            chk($sformatf("vec%0d pkt", i),    32'(pkt_cnt), 32'(vecs[i].pkt));
            chk($sformatf("vec%0d drop", i),   32'(drop_cnt), 32'(vecs[i].drop));
            chk($sformatf("vec%0d err", i),    32'(err), 32'(vecs[i].err));
            chk($sformatf("vec%0d nfull", i),  32'(nfull), 32'(vecs[i].nfull));
        end

        // Reset during word 2 of a packet
        drive(1, 1, 0, 16'hE000); step(); chk_word("mid0", 4'd8, 16'hE000);
        drive(1, 0, 0, 16'hE001); step(); chk_word("mid1", 4'd9, 16'hE001);
        rst = 1'b0;
        drive(1, 0, 0, 16'hE002); step();
        rst = 1'b1;
        chk("mrst wen",    32'(bus.ram_wen), 32'd0);
        chk("mrst waddr",  32'(bus.ram_waddr), 32'd0);
        chk("mrst wdata",  32'(bus.ram_wdata), 32'd0);
        chk("mrst commit", 32'(wr_ptr_commit), 32'd0);
        chk("mrst pkt",    32'(pkt_cnt), 32'd0);
        chk("mrst drop",   32'(drop_cnt), 32'd0);
        chk("mrst err",    32'(err), 32'd0);
        chk("mrst nfull",  32'(nfull), 32'd1);
        drive(1, 1, 0, 16'hE100); step(); chk_word("fresh0", 4'd0, 16'hE100);
        drive(1, 0, 1, 16'hE101); step(); chk_word("fresh1", 4'd1, 16'hE101);
        drive(0, 0, 0, 16'h0);    step();
        chk("fresh commit", 32'(wr_ptr_commit), 32'd2);
        chk("fresh pkt",    32'(pkt_cnt), 32'd1);
        chk("fresh drop",   32'(drop_cnt), 32'd0);

        // Overflow: 20-word packet into an empty 16-deep buffer
        do_reset();
        rd_ptr = '0;
        for (int i = 0; i < 20; i++) begin
            drive(1, (i == 0), (i == 19), 16'(16'hF000 + i));
            step();
            if (i < 16) begin
                chk_word($sformatf("ovf%0d", i), 4'(i), 16'(16'hF000 + i));
            end else begin
                chk($sformatf("ovf%0d wen", i), 32'(bus.ram_wen), 32'd0);
            end
            chk($sformatf("ovf%0d nfull", i), 32'(nfull), (i == 15) ? 32'd0 : 32'd1);
            chk($sformatf("ovf%0d drop", i),  32'(drop_cnt), (i >= 16) ? 32'd1 : 32'd0);
        end
        drive(0, 0, 0, 16'h0); step();
        chk("ovf commit", 32'(wr_ptr_commit), 32'd0);
        chk("ovf pkt",    32'(pkt_cnt), 32'd0);
        drive(1, 1, 1, 16'h5A5A); step(); chk_word("ovf next", 4'd0, 16'h5A5A);
        drive(0, 0, 0, 16'h0); step();
        chk("ovf next commit", 32'(wr_ptr_commit), 32'd1);
        chk("ovf next pkt",    32'(pkt_cnt), 32'd1);

        // Wrap: advance to 14, then a 4-word packet across the end
        do_reset();
        rd_ptr = '0;
        for (int i = 0; i < 14; i++) begin
            drive(1, (i == 0), (i == 13), 16'(16'h1000 + i));
            step();
            chk_word($sformatf("pre%0d", i), 4'(i), 16'(16'h1000 + i));
        end
        drive(0, 0, 0, 16'h0); step();
        chk("pre commit", 32'(wr_ptr_commit), 32'd14);
        rd_ptr = 5'd14;
        for (int i = 0; i < 4; i++) begin
            drive(1, (i == 0), (i == 3), 16'(16'h2000 + i));
            step();
            chk_word($sformatf("wrap%0d", i), 4'((14 + i) % 16), 16'(16'h2000 + i));
            chk($sformatf("wrap%0d nfull", i), 32'(nfull), 32'd1);
        end
        drive(0, 0, 0, 16'h0); step();
        chk("wrap commit", 32'(wr_ptr_commit), 32'h12);
        chk("wrap pkt",    32'(pkt_cnt), 32'd2);
        chk("wrap nfull",  32'(nfull), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
